// File: rtl/ckt_pattern_gen.sv
// ckt_pattern_gen: self-timed stimulus/response stage for the 6-input ckt.
// Steps through NUM_VEC vectors, holding each for HOLD cycles, samples Y in
// the last hold cycle and folds it into a 16-bit MISR plus a ones count.
// Optional macro CKTGEN_LFSR_EN: vectors come from an x^6+x^5+1 LFSR
// seeded with SEED instead of a binary counter starting at 0.
module ckt_pattern_gen #(
    parameter int               WIDTH   = 6,
    parameter int               HOLD    = 4,
    parameter int               NUM_VEC = 64,
    parameter logic [WIDTH-1:0] SEED    = 6'b000001
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         y_in,
    output logic [WIDTH-1:0]             vec,
    output logic                         vec_valid,
    output logic                         sample,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sig,
    output logic [$clog2(NUM_VEC+1)-1:0] ones_cnt
);
    localparam int HCW = $clog2(HOLD);
    localparam int IW  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int OW  = $clog2(NUM_VEC+1);

    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD-1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_VEC-1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [15:0]      sig_q, sig_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [WIDTH-1:0] first_vec, next_vec;

    // Vector source: first vector of a run and successor of the current one
`ifdef CKTGEN_LFSR_EN
    always_comb begin
        first_vec = SEED;
        next_vec  = {vec_q[WIDTH-2:0], vec_q[WIDTH-1] ^ vec_q[WIDTH-2]};
    end
`else
    always_comb begin
        first_vec = '0;
        next_vec  = vec_q + WIDTH'(1);
    end
`endif

    // Next-state: run entry, hold counting, sampling and step advance
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        sig_d      = sig_q;
        ones_d     = ones_q;
        sample     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_DRIVE;
                    hold_cnt_d = '0;
                    idx_d      = '0;
                    vec_d      = first_vec;
                    sig_d      = '0;
                    ones_d     = '0;
                end
            end
            S_DRIVE: begin
                // A paused sample cycle simply repeats, so the sample is deferred, not lost
                sample = (hold_cnt_q == HOLD_LAST) && !pause;
                if (!pause) begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + HCW'(1);
                    end else begin
                        sig_d  = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ y_in};
                        ones_d = ones_q + OW'(y_in);
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d      = idx_q + IW'(1);
                            hold_cnt_d = '0;
                            vec_d      = next_vec;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset that overrides any start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            idx_q      <= '0;
            vec_q      <= '0;
            sig_q      <= '0;
            ones_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            idx_q      <= idx_d;
            vec_q      <= vec_d;
            sig_q      <= sig_d;
            ones_q     <= ones_d;
        end
    end

    assign vec       = vec_q;
    assign vec_valid = (state_q == S_DRIVE);
    assign busy      = (state_q == S_DRIVE);
    assign done      = (state_q == S_DONE);
    assign sig       = sig_q;
    assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_ckt_pattern_gen.sv
// tb_ckt_pattern_gen: randomized and directed bench for ckt_pattern_gen with a
// run-time based reference model (unpaused DRIVE cycles elapsed + queue of Y samples).
module tb_ckt_pattern_gen;
    localparam int W    = 6;
    localparam int HOLD = 4;
    localparam int NV   = 64;
    localparam int OW   = $clog2(NV+1);
    localparam logic [W-1:0] SEED = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, pause = 1'b0, y_in = 1'b0;
    logic [W-1:0]  vec;
    logic          vec_valid, sample, busy, done;
    logic [15:0]   sig;
    logic [OW-1:0] ones_cnt;

    ckt_pattern_gen #(.WIDTH(W), .HOLD(HOLD), .NUM_VEC(NV), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .y_in(y_in),
        .vec(vec), .vec_valid(vec_valid), .sample(sample), .busy(busy),
        .done(done), .sig(sig), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: 0 idle, 1 running, 2 finished; m_t = unpaused running cycles
    int   m_state = 0;
    int   m_t     = 0;
    logic m_ys[$];

    // captured outputs of the latest cycle
    logic [W-1:0]  o_vec;
    logic [15:0]   o_sig;
    logic [OW-1:0] o_ones;
    logic          o_sample, o_busy, o_vv, o_done;
    int            busy_cycles;
    int            samp_cnt;
    logic [W-1:0]  samp_vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // k-th vector of a run
    function automatic logic [W-1:0] vec_at(input int k);
        logic [W-1:0] v;
`ifdef CKTGEN_LFSR_EN
        v = SEED;
        for (int i = 0; i < k; i++) v = {v[4:0], v[5] ^ v[4]};
`else
        v = W'(k % (1 << W));
`endif
        return v;
    endfunction

    function automatic logic [15:0] misr_of_samples();
        logic [15:0] s = '0;
        foreach (m_ys[i]) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ m_ys[i]};
        return s;
    endfunction

    function automatic int ones_of_samples();
        int n = 0;
        foreach (m_ys[i]) n += int'(m_ys[i]);
        return n;
    endfunction

    // One clock: drive inputs, compare outputs against model, advance model
    task automatic cyc(input logic st, input logic pa, input logic yy, input logic rr);
        int k;
        @(negedge clk);
        start = st; pause = pa; y_in = yy; rst = rr;
        #1;
        o_vec = vec; o_sig = sig; o_ones = ones_cnt;
        o_sample = sample; o_busy = busy; o_vv = vec_valid; o_done = done;
        if (chk_en) begin
            k = m_t / HOLD;
            if (k > NV - 1) k = NV - 1;
            chk("vec", 32'(o_vec), (m_state == 0) ? 32'd0 : 32'(vec_at(k)));
            chk("busy", 32'(o_busy), 32'(m_state == 1));
            chk("vec_valid", 32'(o_vv), 32'(m_state == 1));
            chk("done", 32'(o_done), 32'(m_state == 2));
            chk("sample", 32'(o_sample), 32'((m_state == 1) && (m_t % HOLD == HOLD - 1) && !pa));
            chk("sig", 32'(o_sig), 32'(misr_of_samples()));
            chk("ones_cnt", 32'(o_ones), 32'(ones_of_samples()));
        end
        if (o_busy) busy_cycles++;
        if (o_sample) begin
            samp_cnt++;
            samp_vecs.push_back(o_vec);
        end
        @(posedge clk);
        if (rr) begin
            m_state = 0; m_t = 0; m_ys.delete();
        end else if (m_state != 1) begin
            if (st) begin m_state = 1; m_t = 0; m_ys.delete(); end
        end else if (!pa) begin
            if (m_t % HOLD == HOLD - 1) m_ys.push_back(yy);
            m_t++;
            if (m_t == NV * HOLD) m_state = 2;
        end
    endtask

    logic [15:0]   f_sig;
    logic [OW-1:0] f_ones;

    // Start a run and drive it to DONE. ymode: 0 zeros, 1 ones, 2 random
    task automatic run(input int ymode, input bit rnd_start, input int pause_at);
        int  i = 0;
        logic yy, st, pa;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        busy_cycles = 0; samp_cnt = 0; samp_vecs.delete();
        do begin
            yy = (ymode == 2) ? 1'($urandom_range(0, 1)) : 1'(ymode);
            st = rnd_start && (m_state == 1) && ($urandom_range(0, 3) == 0);
            pa = (pause_at >= 0) && (busy_cycles >= pause_at) && (busy_cycles < pause_at + 5);
            cyc(st, pa, yy, 1'b0);
            if (i == 0) begin f_sig = o_sig; f_ones = o_ones; end
            if (pa) begin
                chk("pause_vec", 32'(o_vec), 32'(vec_at(2)));
                chk("pause_sample", 32'(o_sample), 32'd0);
            end
            i++;
        end while (!o_done && i < 700);
        if (!o_done) chk("run_timeout", 32'(o_done), 32'd1);
    endtask

    initial begin
        int n;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        // reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_vec", 32'(o_vec), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sig", 32'(o_sig), 32'd0);
        chk("rst_ones", 32'(o_ones), 32'd0);

        // full run, Y stuck at 1
        run(1, 1'b0, -1);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd256);
        chk("t1_ones", 32'(o_ones), 32'd64);
        chk("t1_samples", 32'(samp_cnt), 32'd64);
`ifdef CKTGEN_LFSR_EN
        chk("lfsr_v0", 32'(samp_vecs[0]), 32'h01);
        chk("lfsr_v1", 32'(samp_vecs[1]), 32'h02);
        chk("lfsr_v2", 32'(samp_vecs[2]), 32'h04);
        chk("lfsr_v3", 32'(samp_vecs[3]), 32'h08);
        chk("lfsr_v4", 32'(samp_vecs[4]), 32'h10);
        chk("lfsr_v5", 32'(samp_vecs[5]), 32'h21);
        chk("lfsr_v6", 32'(samp_vecs[6]), 32'h03);
        n = 0;
        foreach (samp_vecs[i]) if (samp_vecs[i] == '0) n++;
        chk("lfsr_no_zero", 32'(n), 32'd0);
`else
        foreach (samp_vecs[i]) chk("t1_step_vec", 32'(samp_vecs[i]), 32'(i));
`endif

        // restart from DONE, Y stuck at 0, start pulses while driving
        run(0, 1'b1, -1);
        chk("t5_restart_sig", 32'(f_sig), 32'd0);
        chk("t5_restart_ones", 32'(f_ones), 32'd0);
        chk("t2_sig", 32'(o_sig), 32'h0000);
        chk("t2_ones", 32'(o_ones), 32'd0);
        chk("t5_busy_cycles", 32'(busy_cycles), 32'd256);

        // pause 5 cycles in the sample cycle of vector 2
        run(2, 1'b0, 11);
        chk("t3_busy_cycles", 32'(busy_cycles), 32'd261);
        chk("t3_samples", 32'(samp_cnt), 32'd64);

        // reset mid-run at vector 10, then restart
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        busy_cycles = 0;
        n = 0;
        while (busy_cycles < 41 && n < 100) begin
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        chk("t4_at_vec10", 32'(o_vec), 32'(vec_at(10)));
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_vec", 32'(o_vec), 32'd0);
        chk("t4_busy", 32'(o_busy), 32'd0);
        chk("t4_valid", 32'(o_vv), 32'd0);
        chk("t4_done", 32'(o_done), 32'd0);
        chk("t4_sig", 32'(o_sig), 32'd0);
        chk("t4_ones", 32'(o_ones), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_restart_vec", 32'(o_vec), 32'(SEED_OR_ZERO()));
        chk("t4_restart_busy", 32'(o_busy), 32'd1);

        // random soak with pause, start, occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 399) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [W-1:0] SEED_OR_ZERO();
`ifdef CKTGEN_LFSR_EN
        return 6'b000001;
`else
        return 6'b000000;
`endif
    endfunction

endmodule
